// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive types and frame constants
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int   UART_DATA_BITS_DEFAULT = 8;
  localparam logic UART_IDLE_LEVEL        = 1'b1;
  localparam logic UART_START_LEVEL       = 1'b0;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for an asynchronous input
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with valid/ready output and error pulses
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_en,
  output logic                 start_bod,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun_err
);

  localparam int CW = $clog2(DATA_BITS + 1);

  logic                 rx_sync;
  logic                 rx_hist_q, rx_hist_d;
  logic                 fall_edge;
  rx_state_t            state_q, state_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_err_q, overrun_err_d;
  logic                 baud_en_q, baud_en_d;
  logic                 start_bod_q, start_bod_d;

  uart_sync2 #(.RESET_VAL(UART_IDLE_LEVEL)) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  assign fall_edge = (rx_hist_q == UART_IDLE_LEVEL) && (rx_sync == UART_START_LEVEL);

  always_comb begin
    rx_hist_d     = rx_sync;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q && !rx_ready;
    frame_err_d   = 1'b0;
    overrun_err_d = 1'b0;
    // Generator controls follow the registered state, one cycle behind it
    baud_en_d     = (state_q != IDLE);
    start_bod_d   = (state_q == START);

    unique case (state_q)
      IDLE: begin
        if (fall_edge) state_d = START;
      end
      START: begin
        if (baud_tick) begin
          if (rx_sync == UART_START_LEVEL) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (baud_tick) begin
          shift_d   = {rx_sync, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CW'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        if (baud_tick) begin
          state_d = IDLE;
          if (rx_sync == UART_IDLE_LEVEL) begin
            rx_data_d     = shift_q;
            rx_valid_d    = 1'b1;
            overrun_err_d = rx_valid_q && !rx_ready;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hist_q     <= UART_IDLE_LEVEL;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
      baud_en_q     <= 1'b0;
      start_bod_q   <= 1'b0;
    end else begin
      rx_hist_q     <= rx_hist_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
      baud_en_q     <= baud_en_d;
      start_bod_q   <= start_bod_d;
    end
  end

  assign baud_en     = baud_en_q;
  assign start_bod   = start_bod_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
